ram_port_master: RTL and testbench

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_port_master_if.sv | 24 ++
 rtl/ram_port_master.sv | 125 ++++++++++++
 tb/tb_ram_port_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_master_if.sv
// Request/response handshake bundle for ram_port_master.
// The requester uses the master modport; ram_port_master uses the slave modport.
interface ram_port_master_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_port_master.sv
// ram_port_master: turns single-word read/write requests into timed accesses
// on an asynchronous SRAM-style port with a shared tristate data bus.
// Write: one WRITE cycle. Read: READ, RD_CAP (sample bus), TURN (bus
// turnaround, response pulse). Only WRITE drives mem_data.
// Optional build macro RAM_MASTER_STATS_EN adds saturating 16-bit
// wr_count / rd_count outputs.
module ram_port_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_master_if.slave      req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
`ifdef RAM_MASTER_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        RD_CAP = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rsp_valid_q;

    // Ready comes only from the registered state, so req_valid never reaches it.
    assign req.req_ready = (state == IDLE);
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = rdata_q;

    // The bus is driven only while WRITE is the registered state; released otherwise.
    assign mem_data = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

    // Main FSM with registered RAM controls, latched address/data and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_addr    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        mem_addr <= req.req_addr;
                        wdata_q  <= req.req_wdata;
                        mem_cs   <= 1'b1;
                        if (req.req_we) begin
                            state  <= WRITE;
                            mem_we <= 1'b1;
                            mem_oe <= 1'b0;
                        end else begin
                            state  <= READ;
                            mem_we <= 1'b0;
                            mem_oe <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    mem_oe <= 1'b0;
                end
                READ: begin
                    // Give the RAM a full cycle of access time before sampling.
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rdata_q     <= mem_data;
                    rsp_valid_q <= 1'b1;
                    state       <= TURN;
                    mem_cs      <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_oe      <= 1'b0;
                end
                TURN: begin
                    // Idle cycle so the RAM releases the bus before any write.
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    mem_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_MASTER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Access statistics: writes counted as WRITE completes, reads on the response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= 16'd0;
            rd_count <= 16'd0;
        end else begin
            if (state == WRITE) wr_count <= sat_inc(wr_count);
            if (rsp_valid_q)    rd_count <= sat_inc(rd_count);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_master.sv
// Testbench for ram_port_master: table of directed read/write vectors with a
// behavioural SRAM on the tristate bus, plus sequences for reset in RD_CAP,
// back-to-back request spacing and (with RAM_MASTER_STATS_EN) the counters.
module tb_ram_port_master;

    logic        clk;
    logic        rst;
    wire  [15:0] mem_data;
    logic [14:0] mem_addr;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
`ifdef RAM_MASTER_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
`endif

    ram_port_master_if #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) bus ();

    ram_port_master #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (bus),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe)
`ifdef RAM_MASTER_STATS_EN
        ,
        .wr_count (wr_count),
        .rd_count (rd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM.
    logic [15:0] ram [0:32767];
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr] : {16{1'bz}};
    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitors: no block drive while the RAM drives, single-cycle responses.
    bit prev_rsp = 1'b0;
    always @(negedge clk) begin
        if (mem_cs && mem_oe) begin
            chk("rd_we_low", 32'(mem_we), 0);
            chk("rd_bus_clean", 32'(mem_data), 32'(ram[mem_addr]));
        end
        if (bus.rsp_valid) chk("rsp_single_pulse", 32'(prev_rsp), 0);
        prev_rsp <= bus.rsp_valid;
    end

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    // Present a request at a falling edge, wait (bounded) for ready, let the
    // rising edge accept it, and return in cycle 1 with req_valid dropped.
    task automatic accept(input logic we, input logic [14:0] a, input logic [15:0] d,
                          output bit ok);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int k;
        accept(v.we, v.addr, v.wdata, ok);
        if (ok) begin
            if (v.we) begin
                chk({tag, "_wr_cs"},   32'(mem_cs), 1);
                chk({tag, "_wr_we"},   32'(mem_we), 1);
                chk({tag, "_wr_oe"},   32'(mem_oe), 0);
                chk({tag, "_wr_addr"}, 32'(mem_addr), 32'(v.addr));
                chk({tag, "_wr_data"}, 32'(mem_data), 32'(v.wdata));
                @(negedge clk);
                chk({tag, "_wr_ready_c2"}, 32'(bus.req_ready), 1);
                chk({tag, "_addr_hold"},   32'(mem_addr), 32'(v.addr));
                chk({tag, "_ram_commit"},  32'(ram[v.addr]), 32'(v.wdata));
            end else begin
                chk({tag, "_rd_cs"}, 32'(mem_cs), 1);
                chk({tag, "_rd_we"}, 32'(mem_we), 0);
                chk({tag, "_rd_oe"}, 32'(mem_oe), 1);
                chk({tag, "_rd_addr"}, 32'(mem_addr), 32'(v.addr));
                k = 1;
                while (!bus.rsp_valid && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                chk({tag, "_rd_latency"}, 32'(k), 3);
                chk({tag, "_rd_data"}, 32'(bus.rsp_rdata), 32'(v.exp));
                chk({tag, "_turn_idle"}, 32'({mem_cs, mem_we, mem_oe}), 0);
                @(negedge clk);
                chk({tag, "_rd_ready_c4"}, 32'(bus.req_ready), 1);
                chk({tag, "_rdata_hold"}, 32'(bus.rsp_rdata), 32'(v.exp));
            end
        end
    endtask

    initial begin
        bit ok;
        int cyc;
        int last;
        int n;
        int k;

        vecs[0]  = '{1'b1, 15'h1FFC, 16'h3524, 16'h0000};
        vecs[1]  = '{1'b0, 15'h1FFC, 16'h0000, 16'h3524};
        vecs[2]  = '{1'b1, 15'h7FFF, 16'h5E81, 16'h0000};
        vecs[3]  = '{1'b1, 15'h0000, 16'hD609, 16'h0000};
        vecs[4]  = '{1'b0, 15'h7FFF, 16'h0000, 16'h5E81};
        vecs[5]  = '{1'b0, 15'h0000, 16'h0000, 16'hD609};
        vecs[6]  = '{1'b1, 15'h3FFF, 16'h0BAD, 16'h0000};
        vecs[7]  = '{1'b0, 15'h3FFF, 16'h0000, 16'h0BAD};
        vecs[8]  = '{1'b1, 15'h3FFF, 16'h5663, 16'h0000};
        vecs[9]  = '{1'b0, 15'h3FFF, 16'h0000, 16'h5663};
        vecs[10] = '{1'b1, 15'h2AAA, 16'hFFFF, 16'h0000};
        vecs[11] = '{1'b0, 15'h2AAA, 16'h0000, 16'hFFFF};

        // Reset with a request pending: nothing may be accepted.
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 15'h1234;
        bus.req_wdata = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_cs",    32'(mem_cs), 0);
        chk("rst_we",    32'(mem_we), 0);
        chk("rst_oe",    32'(mem_oe), 0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_rsp",   32'(bus.rsp_valid), 0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 1);
        chk("post_rst_cs",    32'(mem_cs), 0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during RD_CAP aborts the read.
        accept(1'b0, 15'h1FFC, 16'h0000, ok);
        @(negedge clk);
        chk("abort_in_rdcap_oe", 32'(mem_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle_ctrl", 32'({mem_cs, mem_we, mem_oe}), 0);
        chk("abort_no_rsp",    32'(bus.rsp_valid), 0);
        chk("abort_rdata_clr", 32'(bus.rsp_rdata), 0);
        chk("abort_ready",     32'(bus.req_ready), 1);
        @(negedge clk);
        chk("abort_no_late_rsp", 32'(bus.rsp_valid), 0);
        chk("abort_no_access",   32'(mem_cs), 0);
        run_vec(vecs[1], "after_abort");

        // Back-to-back requests with req_valid held: spacing 2 per write, 4 per read.
        @(negedge clk);
        bus.req_valid = 1'b1;
        cyc = 0;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req_we    = (i % 2 == 0);
            bus.req_addr  = 15'(256 + i / 2);
            bus.req_wdata = 16'(40960 + i / 2);
            n = 0;
            while (!bus.req_ready && n < 20) begin
                @(negedge clk);
                cyc++;
                n++;
            end
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(cyc - last), (i % 2 == 1) ? 2 : 4);
            last = cyc;
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_last_rdata", 32'(bus.rsp_rdata), 32'h0000A004);
        chk("b2b_ram_0100",   32'(ram[15'h0100]), 32'h0000A000);

`ifdef RAM_MASTER_STATS_EN
        // Counters: 3 writes, 2 reads, then saturation of wr_count.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stats_wr_rst", 32'(wr_count), 0);
        chk("stats_rd_rst", 32'(rd_count), 0);
        run_vec(vecs[0], "st0");
        run_vec(vecs[2], "st1");
        run_vec(vecs[3], "st2");
        run_vec(vecs[1], "st3");
        run_vec(vecs[4], "st4");
        chk("stats_wr_count", 32'(wr_count), 3);
        chk("stats_rd_count", 32'(rd_count), 2);
        force dut.wr_count = 16'hFFFF;
        @(negedge clk);
        release dut.wr_count;
        run_vec(vecs[0], "st_sat");
        chk("stats_wr_sat", 32'(wr_count), 32'h0000FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
